e_mdu_iter: RTL

//  Parametrised E-stage multiply/divide unit with HI/LO registers; replaces the fixed-latency MDU.

---
 rtl/e_mdu_iter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/e_mdu_iter.sv
// E-stage multiply/divide unit: fixed-latency multiply, radix-2 restoring divide, HI/LO state.
// Define MDU_CANCEL_EN to let int_req abort an in-flight operation.
module e_mdu_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             int_req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       MDUop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] MDUresult
);

    localparam int MAXC = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   rem, quo, dvs;
    logic [2*WIDTH-1:0] prod;
    logic               sgn_q;
    logic [CW-1:0]      cnt;

    logic is_mul, is_div, is_sgn, cancel;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        is_sgn = 1'b0;
        case (MDUop)
            4'd1, 4'd9, 4'd11: begin is_mul = 1'b1; is_sgn = 1'b1; end
            4'd2, 4'd10, 4'd12: is_mul = 1'b1;
            4'd3: begin is_div = 1'b1; is_sgn = 1'b1; end
            4'd4: is_div = 1'b1;
            default: ;
        endcase
    end

`ifdef MDU_CANCEL_EN
    assign cancel = int_req;
`else
    assign cancel = 1'b0;
`endif

    // Sign/zero extension to 2*WIDTH makes one unsigned multiply serve both flavours
    logic [2*WIDTH-1:0] ax, bx, prd, mul_res;

    always_comb begin
        ax  = is_sgn ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
        bx  = is_sgn ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
        prd = ax * bx;
        case (MDUop)
            4'd9, 4'd10:  mul_res = {hi, lo} + prd;
            4'd11, 4'd12: mul_res = {hi, lo} - prd;
            default:      mul_res = prd;
        endcase
    end

    logic             sa, sb;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] rem_nx, quo_nx, q_fin, r_fin;

    always_comb begin
        sa     = sgn_q & a_q[WIDTH-1];
        sb     = sgn_q & b_q[WIDTH-1];
        a_abs  = sa ? -a_q : a_q;
        b_abs  = sb ? -b_q : b_q;
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs};
        rem_nx = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nx = {quo[WIDTH-2:0], ~diff[WIDTH]};
        q_fin  = (sa ^ sb) ? -quo_nx : quo_nx;
        r_fin  = sa ? -rem_nx : rem_nx;
        // Zero divisor bypasses sign fix-up so signed matches unsigned behaviour
        if (b_q == '0) begin
            q_fin = '1;
            r_fin = a_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            prod  <= '0;
            sgn_q <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!int_req) begin
                        if (is_mul) begin
                            prod  <= mul_res;
                            cnt   <= CW'(MUL_LAT - 1);
                            busy  <= 1'b1;
                            state <= MUL;
                        end else if (is_div) begin
                            a_q   <= A;
                            b_q   <= B;
                            sgn_q <= is_sgn;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= DIV;
                        end else if (MDUop == 4'd7) begin
                            hi <= A;
                        end else if (MDUop == 4'd8) begin
                            lo <= A;
                        end
                    end
                end
                MUL: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        {hi, lo} <= prod;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DIV: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        rem <= '0;
                        quo <= a_abs;
                        dvs <= b_abs;
                        cnt <= CW'(1);
                    end else if (cnt == CW'(WIDTH)) begin
                        lo    <= q_fin;
                        hi    <= r_fin;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (MDUop)
            4'd5:    MDUresult = hi;
            4'd6:    MDUresult = lo;
            default: MDUresult = '0;
        endcase
    end

endmodule
